// File: rtl/ws2812_color_source.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_color_source
//  Description : Colour source for a single-LED WS2812 driver. Generates a
//                slowly rotating hue-wheel colour (color0), a flash colour
//                (color1) frozen as the complement of color0 at each
//                debounced button press, and a one-cycle press pulse
//                (color_select). Colour words are GRB: [23:16]=G, [15:8]=R,
//                [7:0]=B.
//  Ports       : clk          - system clock
//                rst          - synchronous reset, active-high
//                btn_in       - raw asynchronous push-button, active-high
//                pause        - high freezes the hue rotation
//                color0       - current hue-wheel colour (GRB)
//                color1       - flash colour (GRB)
//                color_select - one-cycle pulse per debounced press
//                press_count  - accepted presses, modulo 256
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_color_source #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int STEP_CYCLES     = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_in,
    input  logic        pause,
    output logic [23:0] color0,
    output logic [23:0] color1,
    output logic        color_select,
    output logic [7:0]  press_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int ST_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [DB_W-1:0] C_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] C_DB_ONE    = DB_W'(1);
    localparam logic [ST_W-1:0] C_STEP_LAST = ST_W'(STEP_CYCLES - 1);
    localparam logic [ST_W-1:0] C_STEP_ONE  = ST_W'(1);

    typedef enum logic [2:0] {
        PH_RY = 3'd0,
        PH_YG = 3'd1,
        PH_GC = 3'd2,
        PH_CB = 3'd3,
        PH_BM = 3'd4,
        PH_MR = 3'd5
    } phase_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic            r_s1;
    logic            r_s2;
    logic            r_stable;
    logic [DB_W-1:0] r_db_cnt;
    logic [ST_W-1:0] r_step_cnt;
    phase_t          r_phase;
    logic [7:0]      r_level;
    logic [23:0]     r_color1;
    logic            r_color_select;
    logic [7:0]      r_press_count;

    logic [7:0]      w_r;
    logic [7:0]      w_g;
    logic [7:0]      w_b;
    logic [23:0]     w_color0;

    // ------------------------------------------------------------------------
    // Synchroniser, debounce and press capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1           <= 1'b0;
            r_s2           <= 1'b0;
            r_stable       <= 1'b0;
            r_db_cnt       <= '0;
            r_color1       <= 24'hFF00FF;
            r_color_select <= 1'b0;
            r_press_count  <= 8'd0;
        end else begin
            r_s1           <= btn_in;
            r_s2           <= r_s1;
            r_color_select <= 1'b0;

            if (r_s2 == r_stable) begin
                // Any agreeing cycle throws away partial qualification.
                r_db_cnt <= '0;
            end else if (r_db_cnt == C_DB_LAST) begin
                r_stable <= r_s2;
                r_db_cnt <= '0;
                if (r_s2) begin
                    // Accepted rising press: w_color0 is still the pre-step
                    // colour here even if the hue advances on this edge.
                    r_color_select <= 1'b1;
                    r_color1       <= ~w_color0;
                    r_press_count  <= r_press_count + 8'd1;
                end
            end else begin
                r_db_cnt <= r_db_cnt + C_DB_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Step timer and hue FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt <= '0;
            r_phase    <= PH_RY;
            r_level    <= 8'd0;
        end else if (!pause) begin
            if (r_step_cnt == C_STEP_LAST) begin
                r_step_cnt <= '0;
                r_level    <= r_level + 8'd1;
                case (r_phase)
                    PH_RY: if (r_level == 8'hFF) r_phase <= PH_YG;
                    PH_YG: if (r_level == 8'hFF) r_phase <= PH_GC;
                    PH_GC: if (r_level == 8'hFF) r_phase <= PH_CB;
                    PH_CB: if (r_level == 8'hFF) r_phase <= PH_BM;
                    PH_BM: if (r_level == 8'hFF) r_phase <= PH_MR;
                    PH_MR: if (r_level == 8'hFF) r_phase <= PH_RY;
                    default: begin
                        // Corrupted phase: restart the wheel cleanly at red.
                        r_phase <= PH_RY;
                        r_level <= 8'd0;
                    end
                endcase
            end else begin
                r_step_cnt <= r_step_cnt + C_STEP_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hue decode: each phase ramps one channel while the others are pinned.
    // ------------------------------------------------------------------------
    always_comb begin
        w_r = 8'h00;
        w_g = 8'h00;
        w_b = 8'h00;
        case (r_phase)
            PH_RY: begin w_r = 8'hFF;           w_g = r_level;         end
            PH_YG: begin w_r = 8'hFF - r_level; w_g = 8'hFF;           end
            PH_GC: begin w_g = 8'hFF;           w_b = r_level;         end
            PH_CB: begin w_g = 8'hFF - r_level; w_b = 8'hFF;           end
            PH_BM: begin w_b = 8'hFF;           w_r = r_level;         end
            PH_MR: begin w_b = 8'hFF - r_level; w_r = 8'hFF;           end
            default: begin
                w_r = 8'h00;
                w_g = 8'h00;
                w_b = 8'h00;
            end
        endcase
    end

    assign w_color0     = {w_g, w_r, w_b};
    assign color0       = w_color0;
    assign color1       = r_color1;
    assign color_select = r_color_select;
    assign press_count  = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_color_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_color_source
//  Description : Self-checking bench for ws2812_color_source with
//                DEBOUNCE_CYCLES=4 and STEP_CYCLES=3. Expected press pulses
//                are queued when a press is driven and matched when the DUT
//                pulses; color0 is compared every cycle against a hue model
//                driven by the count of un-paused clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_color_source;

    localparam int DB = 4;
    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_in = 1'b0;
    logic        pause = 1'b0;
    logic [23:0] color0;
    logic [23:0] color1;
    logic        color_select;
    logic [7:0]  press_count;

    ws2812_color_source #(
        .DEBOUNCE_CYCLES (DB),
        .STEP_CYCLES     (ST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_in       (btn_in),
        .pause        (pause),
        .color0       (color0),
        .color1       (color1),
        .color_select (color_select),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [7:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    int          act_n  = 0;
    bit          mon_en = 1'b0;
    logic [23:0] prev_c = 24'h00FF00;
    logic [7:0]  exp_presses = 8'd0;
    logic [23:0] c_hold;
    int          n_mark;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference hue wheel: step index -> GRB colour.
    function automatic logic [23:0] hue(input int steps);
        int         k;
        int         ph;
        logic [7:0] lv;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        k  = steps % 1536;
        ph = k / 256;
        lv = 8'(k % 256);
        r = 8'h00; g = 8'h00; b = 8'h00;
        case (ph)
            0: begin r = 8'hFF;      g = lv;         end
            1: begin r = ~lv;        g = 8'hFF;      end
            2: begin g = 8'hFF;      b = lv;         end
            3: begin g = ~lv;        b = 8'hFF;      end
            4: begin b = 8'hFF;      r = lv;         end
            default: begin b = ~lv;  r = 8'hFF;      end
        endcase
        return {g, r, b};
    endfunction

    task automatic push_press(input int at);
        exp_presses = exp_presses + 8'd1;
        q.push_back('{at_edge: at, cnt: exp_presses});
    endtask

    // Edge bookkeeping for the model.
    always @(posedge clk) begin
        if (rst) begin
            edge_n <= 0;
            act_n  <= 0;
        end else begin
            edge_n <= edge_n + 1;
            if (!pause) act_n <= act_n + 1;
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check("color0", {8'h00, color0}, {8'h00, hue(act_n / ST)});
            if (q.size() > 0 && q[0].at_edge == edge_n) begin
                m_e = q.pop_front();
                check("pulse", {31'b0, color_select}, 32'd1);
                check("press_count", {24'h0, press_count}, {24'h0, m_e.cnt});
                check("color1", {8'h00, color1}, {8'h00, ~prev_c});
            end else begin
                check("no_pulse", {31'b0, color_select}, 32'd0);
            end
        end
        prev_c = hue(act_n / ST);
    end

    initial begin
        // ---------------- Reset with bouncing button ----------------
        rst = 1'b1; btn_in = 1'b1;
        @(negedge clk); btn_in = 1'b0;
        @(negedge clk); btn_in = 1'b1;
        rst = 1'b0; btn_in = 1'b0;
        mon_en = 1'b1;
        check("rst_color0", {8'h00, color0}, 32'h0000FF00);
        check("rst_color1", {8'h00, color1}, 32'h00FF00FF);
        check("rst_press_count", {24'h0, press_count}, 32'd0);
        check("rst_color_select", {31'b0, color_select}, 32'd0);

        // ---------------- Hue rotation ----------------
        repeat (3 * 256) @(negedge clk);
        check("hue_yg0", {8'h00, color0}, 32'h00FFFF00);
        repeat (1536 * 3 - 3 * 256) @(negedge clk);
        check("hue_full", {8'h00, color0}, 32'h0000FF00);

        // ---------------- Clean press and release ----------------
        btn_in = 1'b1;
        push_press(edge_n + DB + 2);
        repeat (20) @(negedge clk);
        check("clean_count", {24'h0, press_count}, 32'd1);
        btn_in = 1'b0;
        repeat (20) @(negedge clk);

        // ---------------- Bounce ----------------
        n_mark = 0;
        for (int i = 0; i < 40; i++) begin
            btn_in = (i % 4 != 3);
            n_mark = edge_n;
            @(negedge clk);
        end
        btn_in = 1'b1;
        push_press(n_mark + DB + 3);
        repeat (20) @(negedge clk);
        check("bounce_count", {24'h0, press_count}, 32'd2);
        btn_in = 1'b0;
        repeat (20) @(negedge clk);

        // ---------------- Pause mid-step ----------------
        for (int i = 0; i < ST && (act_n % ST) != 1; i++) @(negedge clk);
        c_hold = hue(act_n / ST);
        pause = 1'b1;
        repeat (100) @(negedge clk);
        check("pause_hold", {8'h00, color0}, {8'h00, c_hold});
        pause = 1'b0;
        @(negedge clk);
        check("resume_1", {8'h00, color0}, {8'h00, c_hold});
        @(negedge clk);
        check("resume_2", {8'h00, color0}, {8'h00, hue(act_n / ST)});

        // ---------------- press_count wrap ----------------
        while (exp_presses != 8'd0) begin
            btn_in = 1'b1;
            push_press(edge_n + DB + 2);
            repeat (8) @(negedge clk);
            btn_in = 1'b0;
            repeat (8) @(negedge clk);
        end
        check("wrap_count", {24'h0, press_count}, 32'd0);

        // ---------------- Reset mid-debounce ----------------
        btn_in = 1'b1;
        repeat (DB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_presses = 8'd0;
        check("abort_color_select", {31'b0, color_select}, 32'd0);
        check("abort_color1", {8'h00, color1}, 32'h00FF00FF);
        check("abort_press_count", {24'h0, press_count}, 32'd0);
        push_press(edge_n + DB + 2);
        repeat (20) @(negedge clk);
        btn_in = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_count", {24'h0, press_count}, 32'd1);

        check("pending_pulses", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
